// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - round-robin write-back arbiter for the 32x32 register file (optional bypass: RF_WB_BYPASS_EN)
module rf_wb_arbiter (
   input  logic        Clk,
   input  logic        Clr_n,
   input  logic        Stall,
   input  logic        A_valid,
   input  logic [4:0]  A_rw,
   input  logic [31:0] A_pw,
   output logic        A_ready,
   input  logic        B_valid,
   input  logic [4:0]  B_rw,
   input  logic [31:0] B_pw,
   output logic        B_ready,
   output logic [4:0]  RW,
   output logic [31:0] PW,
   output logic        LE,
   output logic [15:0] Wcount
`ifdef RF_WB_BYPASS_EN
   ,
   input  logic [4:0]  RA,
   input  logic [4:0]  RB,
   input  logic [31:0] PA_rf,
   input  logic [31:0] PB_rf,
   output logic [31:0] PA,
   output logic [31:0] PB
`endif
);

   localparam logic PTR_A = 1'b0;
   localparam logic PTR_B = 1'b1;

   logic        ptr;
   logic        a_xfer;
   logic        b_xfer;
   logic [4:0]  rw_q;
   logic [31:0] pw_q;
   logic        le_q;
   logic [15:0] wcount_q;
   logic        ptr_next;
   logic [4:0]  rw_next;
   logic [31:0] pw_next;
   logic        le_next;

   // Grant: a requester is ready unless the other side is also asking and holds priority.
   // A ready never looks at its own valid, so the two transfers are mutually exclusive.
   always_comb begin
      A_ready = Clr_n & ~Stall & (~B_valid | (ptr == PTR_A));
      B_ready = Clr_n & ~Stall & (~A_valid | (ptr == PTR_B));
      a_xfer  = A_valid & A_ready;
      b_xfer  = B_valid & B_ready;
   end

   // Next pointer and next write command; R0 targets handshake but never raise LE.
   always_comb begin
      ptr_next = ptr;
      rw_next  = rw_q;
      pw_next  = pw_q;
      le_next  = 1'b0;
      if (a_xfer) begin
         ptr_next = PTR_B;
         rw_next  = A_rw;
         pw_next  = A_pw;
         le_next  = (A_rw != 5'd0);
      end else if (b_xfer) begin
         ptr_next = PTR_A;
         rw_next  = B_rw;
         pw_next  = B_pw;
         le_next  = (B_rw != 5'd0);
      end
   end

   // Pointer and registered write command; reset drops any in-flight transfer.
   always_ff @(posedge Clk) begin
      if (!Clr_n) begin
         ptr  <= PTR_A;
         rw_q <= 5'd0;
         pw_q <= 32'd0;
         le_q <= 1'b0;
      end else begin
         ptr  <= ptr_next;
         rw_q <= rw_next;
         pw_q <= pw_next;
         le_q <= le_next;
      end
   end

   // Commit counter: counts the edge at which the register file captures a write, even under Stall.
   always_ff @(posedge Clk) begin
      if (!Clr_n) begin
         wcount_q <= 16'd0;
      end else if (le_q) begin
         wcount_q <= wcount_q + 16'd1;
      end
   end

   assign RW     = rw_q;
   assign PW     = pw_q;
   assign LE     = le_q;
   assign Wcount = wcount_q;

`ifdef RF_WB_BYPASS_EN
   // Forward the committing write so a read in the same cycle sees the new value.
   always_comb begin
      PA = (le_q && (rw_q == RA) && (rw_q != 5'd0)) ? pw_q : PA_rf;
      PB = (le_q && (rw_q == RB) && (rw_q != 5'd0)) ? pw_q : PB_rf;
   end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;

   logic        Clk;
   logic        Clr_n;
   logic        Stall;
   logic        A_valid;
   logic [4:0]  A_rw;
   logic [31:0] A_pw;
   logic        A_ready;
   logic        B_valid;
   logic [4:0]  B_rw;
   logic [31:0] B_pw;
   logic        B_ready;
   logic [4:0]  RW;
   logic [31:0] PW;
   logic        LE;
   logic [15:0] Wcount;
`ifdef RF_WB_BYPASS_EN
   logic [4:0]  RA;
   logic [4:0]  RB;
   logic [31:0] PA_rf;
   logic [31:0] PB_rf;
   logic [31:0] PA;
   logic [31:0] PB;
`endif

   rf_wb_arbiter dut (
      .Clk     (Clk),
      .Clr_n   (Clr_n),
      .Stall   (Stall),
      .A_valid (A_valid),
      .A_rw    (A_rw),
      .A_pw    (A_pw),
      .A_ready (A_ready),
      .B_valid (B_valid),
      .B_rw    (B_rw),
      .B_pw    (B_pw),
      .B_ready (B_ready),
      .RW      (RW),
      .PW      (PW),
      .LE      (LE),
      .Wcount  (Wcount)
`ifdef RF_WB_BYPASS_EN
      ,
      .RA      (RA),
      .RB      (RB),
      .PA_rf   (PA_rf),
      .PB_rf   (PB_rf),
      .PA      (PA),
      .PB      (PB)
`endif
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Register file model: writes any address on LE, so a stray R0 write is visible.
   logic [31:0] rf [32];
   logic        rf_clear;
   always @(posedge Clk) begin
      if (rf_clear) begin
         for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
      end else if (LE) begin
         rf[RW] <= PW;
      end
   end

   int total;
   int bad;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        stall;
      logic        av;
      logic [4:0]  arw;
      logic [31:0] apw;
      logic        bv;
      logic [4:0]  brw;
      logic [31:0] bpw;
      logic        ear;
      logic        ebr;
      logic        ele;
      logic [4:0]  erw;
      logic [31:0] epw;
      logic [15:0] ewc;
   } vec_t;

   function automatic vec_t mk(input logic st, input logic av, input logic [4:0] arw, input logic [31:0] apw,
                               input logic bv, input logic [4:0] brw, input logic [31:0] bpw,
                               input logic ear, input logic ebr, input logic ele,
                               input logic [4:0] erw, input logic [31:0] epw, input logic [15:0] ewc);
      vec_t v;
      v.stall = st; v.av = av; v.arw = arw; v.apw = apw;
      v.bv = bv; v.brw = brw; v.bpw = bpw;
      v.ear = ear; v.ebr = ebr; v.ele = ele; v.erw = erw; v.epw = epw; v.ewc = ewc;
      return v;
   endfunction

   // Inputs are applied just after a rising edge; readies are sampled at the falling edge,
   // registered outputs just after the following rising edge.
   task automatic apply(input vec_t v, input int idx);
      Stall = v.stall; A_valid = v.av; A_rw = v.arw; A_pw = v.apw;
      B_valid = v.bv; B_rw = v.brw; B_pw = v.bpw;
      @(negedge Clk);
      chk($sformatf("v%0d A_ready", idx), {31'd0, A_ready}, {31'd0, v.ear});
      chk($sformatf("v%0d B_ready", idx), {31'd0, B_ready}, {31'd0, v.ebr});
      @(posedge Clk); #1;
      chk($sformatf("v%0d LE", idx), {31'd0, LE}, {31'd0, v.ele});
      chk($sformatf("v%0d RW", idx), {27'd0, RW}, {27'd0, v.erw});
      chk($sformatf("v%0d PW", idx), PW, v.epw);
      chk($sformatf("v%0d Wcount", idx), {16'd0, Wcount}, {16'd0, v.ewc});
   endtask

   vec_t vecs[16];

   initial begin
      total = 0; bad = 0;
      Clr_n = 1'b0; Stall = 1'b0; rf_clear = 1'b1;
      A_valid = 1'b1; A_rw = 5'd1; A_pw = 32'h1;
      B_valid = 1'b1; B_rw = 5'd2; B_pw = 32'h2;
`ifdef RF_WB_BYPASS_EN
      RA = 5'd0; RB = 5'd0; PA_rf = 32'd0; PB_rf = 32'd0;
`endif

      //            st av arw   apw          bv brw   bpw          ar br le rw    pw           wc
      vecs[0]  = mk(0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,       1, 0, 1, 5'd5, 32'hDEADBEEF, 16'd0);
      vecs[1]  = mk(0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,       1, 1, 0, 5'd5, 32'hDEADBEEF, 16'd1);
      vecs[2]  = mk(0, 0, 5'd0, 32'h0,        1, 5'd9, 32'h99,      0, 1, 1, 5'd9, 32'h99,       16'd1);
      vecs[3]  = mk(0, 1, 5'd1, 32'hA1,       1, 5'd11, 32'hB11,    1, 0, 1, 5'd1, 32'hA1,       16'd2);
      vecs[4]  = mk(0, 1, 5'd2, 32'hA2,       1, 5'd11, 32'hB11,    0, 1, 1, 5'd11, 32'hB11,     16'd3);
      vecs[5]  = mk(0, 1, 5'd2, 32'hA2,       1, 5'd12, 32'hB12,    1, 0, 1, 5'd2, 32'hA2,       16'd4);
      vecs[6]  = mk(0, 1, 5'd3, 32'hA3,       1, 5'd12, 32'hB12,    0, 1, 1, 5'd12, 32'hB12,     16'd5);
      vecs[7]  = mk(0, 0, 5'd0, 32'h0,        1, 5'd0, 32'hFFFFFFFF, 1, 1, 0, 5'd0, 32'hFFFFFFFF, 16'd6);
      vecs[8]  = mk(0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,       1, 1, 0, 5'd0, 32'hFFFFFFFF, 16'd6);
      vecs[9]  = mk(1, 1, 5'd20, 32'h2020,    0, 5'd0, 32'h0,       0, 0, 0, 5'd0, 32'hFFFFFFFF, 16'd6);
      vecs[10] = mk(1, 1, 5'd20, 32'h2020,    0, 5'd0, 32'h0,       0, 0, 0, 5'd0, 32'hFFFFFFFF, 16'd6);
      vecs[11] = mk(0, 1, 5'd20, 32'h2020,    0, 5'd0, 32'h0,       1, 0, 1, 5'd20, 32'h2020,    16'd6);
      vecs[12] = mk(1, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,       0, 0, 0, 5'd20, 32'h2020,    16'd7);
      vecs[13] = mk(0, 1, 5'd3, 32'h0A,       1, 5'd3, 32'h0B,      0, 1, 1, 5'd3, 32'h0B,       16'd7);
      vecs[14] = mk(0, 1, 5'd3, 32'h0A,       0, 5'd0, 32'h0,       1, 0, 1, 5'd3, 32'h0A,       16'd8);
      vecs[15] = mk(0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,       1, 1, 0, 5'd3, 32'h0A,       16'd9);

      // Reset held 3 cycles with both requesters asserting.
      for (int c = 0; c < 3; c++) begin
         @(negedge Clk);
         chk("rst A_ready", {31'd0, A_ready}, 32'd0);
         chk("rst B_ready", {31'd0, B_ready}, 32'd0);
         @(posedge Clk); #1;
         chk("rst LE", {31'd0, LE}, 32'd0);
         chk("rst RW", {27'd0, RW}, 32'd0);
         chk("rst PW", PW, 32'd0);
         chk("rst Wcount", {16'd0, Wcount}, 32'd0);
      end
      Clr_n = 1'b1; rf_clear = 1'b0;

      for (int i = 0; i < 16; i++) apply(vecs[i], i);

      chk("rf R5", rf[5], 32'hDEADBEEF);
      chk("rf R0", rf[0], 32'h0);
      chk("rf R1", rf[1], 32'hA1);
      chk("rf R12", rf[12], 32'hB12);
      chk("rf R3 later wins", rf[3], 32'h0A);
      chk("rf R20", rf[20], 32'h2020);

      // Reset asserted in what would be a transfer cycle: the request is dropped.
      Clr_n = 1'b0; Stall = 1'b0;
      A_valid = 1'b1; A_rw = 5'd6; A_pw = 32'h66;
      B_valid = 1'b0;
      @(negedge Clk);
      chk("clr A_ready", {31'd0, A_ready}, 32'd0);
      @(posedge Clk); #1;
      chk("clr LE", {31'd0, LE}, 32'd0);
      chk("clr RW", {27'd0, RW}, 32'd0);
      chk("clr Wcount", {16'd0, Wcount}, 32'd0);
      Clr_n = 1'b1;
      // Re-presented request after reset; pointer restarted at A, so A wins against B.
      B_valid = 1'b1; B_rw = 5'd7; B_pw = 32'h77;
      @(negedge Clk);
      chk("rerun A_ready", {31'd0, A_ready}, 32'd1);
      chk("rerun B_ready", {31'd0, B_ready}, 32'd0);
      chk("rf R6 untouched", rf[6], 32'd0);
      @(posedge Clk); #1;
      chk("rerun LE", {31'd0, LE}, 32'd1);
      chk("rerun RW", {27'd0, RW}, 32'd6);
      chk("rerun PW", PW, 32'h66);
      A_valid = 1'b0; B_valid = 1'b0;
      @(posedge Clk); #1;
      chk("rf R6 written", rf[6], 32'h66);
      chk("rerun Wcount", {16'd0, Wcount}, 32'd1);

`ifdef RF_WB_BYPASS_EN
      A_valid = 1'b1; A_rw = 5'd7; A_pw = 32'h12345678;
      @(posedge Clk); #1;
      A_valid = 1'b0;
      RA = 5'd7; RB = 5'd8; PA_rf = 32'hAAAA0000; PB_rf = 32'h55;
      #1;
      chk("byp PA hit", PA, 32'h12345678);
      chk("byp PB miss", PB, 32'h55);
      RA = 5'd8;
      #1;
      chk("byp PA miss", PA, 32'hAAAA0000);
      @(posedge Clk); #1;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running want finished");
      $fatal(1);
   end

endmodule
